// File: rtl/op_sequencer.sv
// op_sequencer: multi-cycle ALU sequencer. Reads two operands from an
// external register file, applies a shift to B, executes ADD/SUB/AND/NOT,
// writes the result back and reports {Z,N,V} status.
module op_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [2:0]   rn,
  input  logic [2:0]   rm,
  input  logic [2:0]   rd,
  input  logic [1:0]   op,
  input  logic [1:0]   shift,
  input  logic [W-1:0] rf_data,
  output logic [2:0]   readnum,
  output logic [2:0]   writenum,
  output logic         write,
  output logic [W-1:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [2:0]   status
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_A = 3'd1;
  localparam logic [2:0] RD_B = 3'd2;
  localparam logic [2:0] EXEC = 3'd3;
  localparam logic [2:0] WB   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]   state, next_state;
  logic [2:0]   rm_q, rd_q;
  logic [1:0]   op_q, shift_q;
  logic [W-1:0] a, b, c;
  logic [W-1:0] b_sh, sum, diff, result;
  logic [2:0]   flags;
  logic         v;

  // Fixed linear sequence; start is only looked at in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? RD_A : IDLE;
      RD_A:    next_state = RD_B;
      RD_B:    next_state = EXEC;
      EXEC:    next_state = WB;
      WB:      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Shift B, compute the result and the {Z,N,V} flags.
  always_comb begin
    b_sh = b;
    case (shift_q)
      2'b01:   b_sh = {b[W-2:0], 1'b0};
      2'b10:   b_sh = {1'b0, b[W-1:1]};
      2'b11:   b_sh = {b[W-1], b[W-1:1]};
      default: b_sh = b;
    endcase
    sum    = a + b_sh;
    diff   = a - b_sh;
    result = '0;
    v      = 1'b0;
    case (op_q)
      2'b00: begin
        result = sum;
        v      = (a[W-1] == b_sh[W-1]) && (sum[W-1] != a[W-1]);
      end
      2'b01: begin
        result = diff;
        v      = (a[W-1] != b_sh[W-1]) && (diff[W-1] != a[W-1]);
      end
      2'b10:   result = a & b_sh;
      default: result = ~b_sh;
    endcase
    flags = {(result == '0), result[W-1], v};
  end

  // Datapath registers: captured fields, operands, result and status.
  // readnum is registered one edge ahead so it already holds rn in RD_A
  // and rm in RD_B, and simply holds otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rm_q     <= '0;
      rd_q     <= '0;
      op_q     <= '0;
      shift_q  <= '0;
      readnum  <= '0;
      writenum <= '0;
      data_in  <= '0;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      status   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rm_q    <= rm;
          rd_q    <= rd;
          op_q    <= op;
          shift_q <= shift;
          readnum <= rn;
        end
        RD_A: begin
          a       <= rf_data;
          readnum <= rm_q;
        end
        RD_B: b <= rf_data;
        EXEC: begin
          c        <= result;
          data_in  <= result;
          writenum <= rd_q;
          status   <= flags;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign write = (state == WB);
  assign done  = (state == DONE);

endmodule
